// File: rtl/pci_defs.sv
// rtl/pci_defs.sv - shared arbiter state encodings and active-low bus constants
package pci_defs;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/pci_rr_pick.sv
// rtl/pci_rr_pick.sv - combinational round-robin picker over active-low requests
module pci_rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic [IW-1:0]          ptr,
  output logic [IW-1:0]          winner,
  output logic                   any_req
);

  int idx;

  // Scan downward so the last hit written is the one closest to ptr.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!req_n[IW'(idx)]) begin
        winner  = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// rtl/pci_bus_arbiter.sv - round-robin PCI REQ/GNT arbiter with turnaround and idle timeout
// Optional bus parking on PARK_MASTER when built with PCI_ARB_PARK_EN defined.
module pci_bus_arbiter
  import pci_defs::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int PARK_MASTER = 0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_MASTERS-1:0]         REQ,
  input  logic                           FRAME,
  input  logic                           IRDY,
  output logic [NUM_MASTERS-1:0]         GNT,
  output logic [$clog2(NUM_MASTERS)-1:0] OWNER,
  output logic                           GNT_VALID
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] PARK_IDX  = IW'(PARK_MASTER);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_MASTERS - 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [NUM_MASTERS-1:0] ALL_OFF = {NUM_MASTERS{DEASSERT_N}};

`ifdef PCI_ARB_PARK_EN
  localparam bit PARK_EN = 1'b1;
`else
  localparam bit PARK_EN = 1'b0;
`endif

  arb_state_e state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic valid_q, valid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic started_q, started_d;

  logic bus_idle;
  logic [IW-1:0] winner;
  logic any_req;
  logic [NUM_MASTERS-1:0] owner_mask, park_mask;
  logic others_req, park_others_req;
  logic [TW-1:0] timer_inc;
  logic release_now;

  pci_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IW         (IW)
  ) u_pick (
    .req_n  (REQ),
    .ptr    (ptr_q),
    .winner (winner),
    .any_req(any_req)
  );

  always_comb begin
    bus_idle = FRAME & IRDY;
    owner_mask = '0;
    owner_mask[owner_q] = 1'b1;
    park_mask = '0;
    park_mask[PARK_IDX] = 1'b1;
    others_req      = |(~REQ & ~owner_mask);
    park_others_req = |(~REQ & ~park_mask);
    // Idle clocks only count against an owner that has not yet started a FRAME.
    timer_inc = timer_q;
    if (bus_idle && !started_q && (timer_q != TIMEOUT_V)) timer_inc = timer_q + TW'(1);
    release_now = REQ[owner_q] || (others_req && started_q) || (timer_inc == TIMEOUT_V);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    started_d = started_q;
    case (state_q)
      ARB_IDLE: begin
        if (PARK_EN) begin
          gnt_d           = ALL_OFF;
          gnt_d[PARK_IDX] = ASSERT_N;
          owner_d         = PARK_IDX;
          valid_d         = 1'b1;
          if (!FRAME) begin
            state_d   = ARB_GRANT;
            timer_d   = '0;
            started_d = 1'b1;
          end else if (park_others_req) begin
            state_d = ARB_TURN;
            gnt_d   = ALL_OFF;
            valid_d = 1'b0;
          end else if (!REQ[PARK_IDX]) begin
            state_d   = ARB_GRANT;
            timer_d   = '0;
            started_d = 1'b0;
          end
        end else begin
          gnt_d   = ALL_OFF;
          valid_d = 1'b0;
          if (any_req && bus_idle) begin
            state_d       = ARB_GRANT;
            gnt_d[winner] = ASSERT_N;
            owner_d       = winner;
            valid_d       = 1'b1;
            timer_d       = '0;
            started_d     = 1'b0;
          end
        end
      end
      ARB_GRANT: begin
        started_d = started_q | ~FRAME;
        timer_d   = timer_inc;
        if (release_now) begin
          state_d = ARB_TURN;
          gnt_d   = ALL_OFF;
          valid_d = 1'b0;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
        end
      end
      ARB_TURN: begin
        if (bus_idle) begin
          if (any_req) begin
            state_d       = ARB_GRANT;
            gnt_d         = ALL_OFF;
            gnt_d[winner] = ASSERT_N;
            owner_d       = winner;
            valid_d       = 1'b1;
            timer_d       = '0;
            started_d     = 1'b0;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= ALL_OFF;
      owner_q   <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
      timer_q   <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      started_q <= started_d;
    end
  end

  assign GNT       = gnt_q;
  assign OWNER     = owner_q;
  assign GNT_VALID = valid_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb/tb_pci_bus_arbiter.sv - vector table, directed corner cases and randomized model check
module tb_pci_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic       FRAME;
  logic       IRDY;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       GNT_VALID;

  int checks = 0;
  int failures = 0;

  pci_bus_arbiter #(
    .NUM_MASTERS(N),
    .TIMEOUT    (TO),
    .PARK_MASTER(0)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .FRAME    (FRAME),
    .IRDY     (IRDY),
    .GNT      (GNT),
    .OWNER    (OWNER),
    .GNT_VALID(GNT_VALID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Reference model: who holds the bus (-1 = nobody), whether a turnaround is pending.
  int m_holder, m_last, m_ptr, m_timer;
  bit m_turn, m_started;

  task automatic model_reset();
    m_holder = -1; m_last = 0; m_ptr = 0; m_timer = 0;
    m_turn = 0; m_started = 0;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (!r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit idle, others, rel;
    int w;
    idle = FRAME & IRDY;
    w = pick(REQ, m_ptr);
    if (m_holder >= 0) begin
      others = 0;
      for (int k = 0; k < N; k++) if (k != m_holder && !REQ[k]) others = 1;
      if (idle && !m_started && m_timer < TO) m_timer++;
      rel = REQ[m_holder] || (others && m_started) || (m_timer == TO);
      if (!FRAME) m_started = 1;
      if (rel) begin
        m_ptr = (m_holder + 1) % N;
        m_holder = -1;
        m_turn = 1;
      end
    end else if (idle) begin
      m_turn = 0;
      if (w >= 0) begin
        m_holder = w; m_last = w; m_timer = 0; m_started = 0;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    logic [3:0] g;
    g = 4'b1111;
    if (m_holder >= 0) g[m_holder] = 1'b0;
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic f, input logic i);
    REQ = r; FRAME = f; IRDY = i;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(4'b1111, 1'b1, 1'b1);
    RST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       frame;
    logic       irdy;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       valid;
  } vec_t;

  vec_t rr_tab[13];
  logic [3:0] rnd_req;

  initial begin
    rr_tab[0]  = '{4'b0000, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1};
    rr_tab[1]  = '{4'b0000, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1};
    rr_tab[2]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b0};
    rr_tab[3]  = '{4'b0000, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1};
    rr_tab[4]  = '{4'b0000, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
    rr_tab[5]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 2'd1, 1'b0};
    rr_tab[6]  = '{4'b0000, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1};
    rr_tab[7]  = '{4'b0000, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b1};
    rr_tab[8]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 2'd2, 1'b0};
    rr_tab[9]  = '{4'b0000, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1};
    rr_tab[10] = '{4'b0000, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b1};
    rr_tab[11] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 2'd3, 1'b0};
    rr_tab[12] = '{4'b0000, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1};

    RST = 1'b0;
    drive(4'b0000, 1'b1, 1'b1);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_gnt", GNT, 4'b1111);
    chk("reset_valid", GNT_VALID, 1'b0);
    chk("reset_owner", OWNER, 2'd0);
    RST = 1'b1;

`ifdef PCI_ARB_PARK_EN
    do_reset();
    drive(4'b1111, 1'b1, 1'b1);
    tick();
    chk("park_gnt", GNT, 4'b1110);
    chk("park_valid", GNT_VALID, 1'b1);
    chk("park_owner", OWNER, 2'd0);
    drive(4'b0111, 1'b1, 1'b1);
    tick();
    chk("park_turn_gnt", GNT, 4'b1111);
    tick();
    chk("park_regrant_gnt", GNT, 4'b0111);
    chk("park_regrant_owner", OWNER, 2'd3);
`else
    for (int i = 0; i < 13; i++) begin
      drive(rr_tab[i].req, rr_tab[i].frame, rr_tab[i].irdy);
      tick();
      chk($sformatf("rr_gnt[%0d]", i), GNT, rr_tab[i].gnt);
      chk($sformatf("rr_owner[%0d]", i), OWNER, rr_tab[i].owner);
      chk($sformatf("rr_valid[%0d]", i), GNT_VALID, rr_tab[i].valid);
    end

    // Turnaround must wait for FRAME and IRDY both high.
    do_reset();
    drive(4'b1101, 1'b1, 1'b1);
    tick();
    chk("ta_grant1", GNT, 4'b1101);
    drive(4'b1101, 1'b0, 1'b1);
    tick();
    chk("ta_started", GNT, 4'b1101);
    drive(4'b1001, 1'b0, 1'b1);
    tick();
    chk("ta_release", GNT, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ta_busy[%0d]", k), GNT, 4'b1111);
    end
    drive(4'b1001, 1'b1, 1'b0);
    tick();
    chk("ta_irdy_low", GNT, 4'b1111);
    drive(4'b1001, 1'b1, 1'b1);
    tick();
    chk("ta_grant2", GNT, 4'b1011);
    chk("ta_owner2", OWNER, 2'd2);

    // Idle timeout then re-grant of the sole requester.
    do_reset();
    drive(4'b1101, 1'b1, 1'b1);
    tick();
    chk("to_grant", GNT, 4'b1101);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk($sformatf("to_hold[%0d]", k), GNT, 4'b1101);
    end
    tick();
    chk("to_expire", GNT, 4'b1111);
    chk("to_expire_valid", GNT_VALID, 1'b0);
    tick();
    chk("to_regrant", GNT, 4'b1101);
    chk("to_regrant_owner", OWNER, 2'd1);

    // Asynchronous reset mid-transaction; pointer (now 2) must return to 0.
    drive(4'b1101, 1'b0, 1'b1);
    #3;
    RST = 1'b0;
    #1;
    chk("arst_gnt", GNT, 4'b1111);
    chk("arst_valid", GNT_VALID, 1'b0);
    chk("arst_owner", OWNER, 2'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    drive(4'b0000, 1'b1, 1'b1);
    tick();
    chk("arst_ptr_gnt", GNT, 4'b1110);
    chk("arst_ptr_owner", OWNER, 2'd0);

    // Sole owner keeps the bus across many transactions.
    do_reset();
    drive(4'b1011, 1'b1, 1'b1);
    tick();
    chk("sole_grant", GNT, 4'b1011);
    for (int k = 0; k < 100; k++) begin
      if ((k % 10) >= 2 && (k % 10) <= 4) drive(4'b1011, 1'b0, 1'b0);
      else drive(4'b1011, 1'b1, 1'b1);
      tick();
      chk($sformatf("sole_hold[%0d]", k), GNT, 4'b1011);
    end

    // Randomized traffic against the reference model.
    do_reset();
    rnd_req = 4'b1111;
    for (int seg = 0; seg < 15; seg++) begin
      int fpct, rpct;
      fpct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 8 : 40);
      rpct = 20 + 20 * (seg % 4);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(99) < 25) begin
          for (int b = 0; b < N; b++) rnd_req[b] = ($urandom_range(99) < rpct) ? 1'b0 : 1'b1;
        end
        drive(rnd_req,
              ($urandom_range(99) < fpct) ? 1'b0 : 1'b1,
              ($urandom_range(99) < fpct / 2) ? 1'b0 : 1'b1);
        tick();
        chk("rnd_gnt", GNT, exp_gnt());
        chk("rnd_owner", OWNER, m_last);
        chk("rnd_valid", GNT_VALID, m_holder >= 0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
